neighbor_rule_pipe: RTL and testbench

Parametrised, pipelined successor to the combinational 8-neighbor adder. It accepts one cell per transfer: the cell's current state plus N neighbor bits. It counts the live neighbors through a registered adder tree and applies a birth/survive rule. It returns the cell's next state, the neighbor count and a changed flag. It sits between the board-state memory scanner and the next-generation write-back, with valid/ready flow control on both sides.

---
 rtl/neighbor_rule_pipe.sv | 153 +++++++++++++++
 tb/tb_neighbor_rule_pipe.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neighbor_rule_pipe.sv
// Pipelined live-neighbor counter with a configurable birth/survive rule.
// A registered pairwise adder tree counts the neighbor bits. A registered rule
// stage then produces the next cell state. All stages stall together whenever
// the output beat is held.
module neighbor_rule_pipe #(
  parameter int unsigned N_NEIGHBORS = 8,
  localparam int unsigned CNT_W = $clog2(N_NEIGHBORS + 1),
  parameter logic [N_NEIGHBORS:0] DEF_BIRTH = (N_NEIGHBORS + 1)'(1) << 3,
  parameter logic [N_NEIGHBORS:0] DEF_SURVIVE = ((N_NEIGHBORS + 1)'(1) << 2) |
                                               ((N_NEIGHBORS + 1)'(1) << 3)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_load,
  input  logic [N_NEIGHBORS:0]   cfg_birth,
  input  logic [N_NEIGHBORS:0]   cfg_survive,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_state,
  input  logic [N_NEIGHBORS-1:0] in_neighbors,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CNT_W-1:0]       out_count,
  output logic                   out_next_state,
  output logic                   out_changed,
  output logic                   busy
);

  localparam int unsigned LVL = $clog2(N_NEIGHBORS);

  // Operand count entering adder level l.
  function automatic int unsigned lvl_in(input int unsigned l);
    int unsigned n;
    n = N_NEIGHBORS;
    for (int unsigned k = 0; k < l; k++) n = (n + 1) / 2;
    return n;
  endfunction

  // Sum count produced by adder level l.
  function automatic int unsigned lvl_cnt(input int unsigned l);
    return (lvl_in(l) + 1) / 2;
  endfunction

  // Position of level l's first sum within the flattened tree vector.
  function automatic int unsigned lvl_off(input int unsigned l);
    int unsigned off;
    off = 0;
    for (int unsigned k = 0; k < l; k++) off += lvl_cnt(k);
    return off;
  endfunction

  localparam int unsigned TOT = lvl_off(LVL);

  // Every tree level is kept at CNT_W bits. The value never exceeds N_NEIGHBORS,
  // so the upper bits of the early levels are constant zero. Synthesis trims
  // them away.
  logic [TOT*CNT_W-1:0]   r_tree;
  logic [TOT*CNT_W-1:0]   w_tree;
  logic [LVL-1:0]         r_vld;
  logic [LVL-1:0]         r_st;
  logic                   r_out_vld;
  logic [CNT_W-1:0]       r_out_cnt;
  logic                   r_out_next;
  logic                   r_out_chg;
  logic [N_NEIGHBORS:0]   r_birth;
  logic [N_NEIGHBORS:0]   r_survive;

  logic                   w_adv;
  logic                   w_acc;
  logic [N_NEIGHBORS-1:0] w_nb;
  logic                   w_st;
  logic [CNT_W-1:0]       w_cnt;
  logic                   w_rule;
  logic                   w_next;

  assign w_adv    = !r_out_vld || out_ready;
  assign in_ready = w_adv;
  assign w_acc    = in_valid && w_adv;
  // Idle beats enter as zeros, so don't-care inputs never reach the outputs.
  assign w_nb     = in_neighbors & {N_NEIGHBORS{in_valid}};
  assign w_st     = in_state & in_valid;

  for (genvar l = 0; l < LVL; l++) begin : g_lvl
    for (genvar i = 0; i < lvl_cnt(l); i++) begin : g_sum
      localparam int unsigned OO = lvl_off(l) + i;
      if (l == 0) begin : g_leaf
        if (2 * i + 1 < N_NEIGHBORS) begin : g_pair
          assign w_tree[OO*CNT_W +: CNT_W] = CNT_W'(w_nb[2*i]) + CNT_W'(w_nb[2*i+1]);
        end else begin : g_pass
          assign w_tree[OO*CNT_W +: CNT_W] = CNT_W'(w_nb[2*i]);
        end
      end else begin : g_node
        localparam int unsigned OI = lvl_off(l) - lvl_in(l);
        if (2 * i + 1 < lvl_in(l)) begin : g_pair
          assign w_tree[OO*CNT_W +: CNT_W] = r_tree[(OI+2*i)*CNT_W +: CNT_W] +
                                             r_tree[(OI+2*i+1)*CNT_W +: CNT_W];
        end else begin : g_pass
          assign w_tree[OO*CNT_W +: CNT_W] = r_tree[(OI+2*i)*CNT_W +: CNT_W];
        end
      end
    end
  end

  // Rule lookup on the final tree sum. The result is forced low for a bubble.
  always_comb begin
    w_cnt  = r_tree[(TOT-1)*CNT_W +: CNT_W];
    w_rule = r_st[LVL-1] ? r_survive[w_cnt] : r_birth[w_cnt];
    w_next = w_rule & r_vld[LVL-1];
  end

  // Rule mask registers. A load takes effect after the edge that captures it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_birth   <= DEF_BIRTH;
      r_survive <= DEF_SURVIVE;
    end else if (cfg_load) begin
      r_birth   <= cfg_birth;
      r_survive <= cfg_survive;
    end
  end

  // Adder-tree and rule-stage pipeline. All stages advance together under w_adv.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tree     <= '0;
      r_vld      <= '0;
      r_st       <= '0;
      r_out_vld  <= 1'b0;
      r_out_cnt  <= '0;
      r_out_next <= 1'b0;
      r_out_chg  <= 1'b0;
    end else if (w_adv) begin
      r_tree   <= w_tree;
      r_vld[0] <= w_acc;
      r_st[0]  <= w_st;
      for (int unsigned k = 1; k < LVL; k++) begin
        r_vld[k] <= r_vld[k-1];
        r_st[k]  <= r_st[k-1];
      end
      r_out_vld  <= r_vld[LVL-1];
      r_out_cnt  <= w_cnt;
      r_out_next <= w_next;
      r_out_chg  <= w_next ^ r_st[LVL-1];
    end
  end

  assign out_valid      = r_out_vld;
  assign out_count      = r_out_cnt;
  assign out_next_state = r_out_next;
  assign out_changed    = r_out_chg;
  assign busy           = (|r_vld) | r_out_vld;

endmodule

// File: tb/tb_neighbor_rule_pipe.sv
// Self-checking bench for neighbor_rule_pipe. It runs an N=8 and an N=5 instance
// against a popcount/rule scoreboard model, plus literal directed expectations.
module tb_neighbor_rule_pipe;

  typedef struct {
    int cnt;
    bit nxt;
    bit chg;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // N=8 instance signals
  logic       v8 = 0, s8 = 0, r8, ov8, or8 = 1, nx8, ch8, b8, cl8 = 0;
  logic [7:0] n8 = '0;
  logic [3:0] c8;
  logic [8:0] cb8 = '0, cs8 = '0;
  // N=5 instance signals
  logic       v5 = 0, s5 = 0, r5, ov5, or5 = 1, nx5, ch5, b5, cl5 = 0;
  logic [4:0] n5 = '0;
  logic [2:0] c5;
  logic [5:0] cb5 = '0, cs5 = '0;

  neighbor_rule_pipe #(.N_NEIGHBORS(8)) u_d8 (
    .clk(clk), .rst(rst_n), .cfg_load(cl8), .cfg_birth(cb8), .cfg_survive(cs8),
    .in_valid(v8), .in_ready(r8), .in_state(s8), .in_neighbors(n8),
    .out_valid(ov8), .out_ready(or8), .out_count(c8), .out_next_state(nx8),
    .out_changed(ch8), .busy(b8));

  neighbor_rule_pipe #(.N_NEIGHBORS(5)) u_d5 (
    .clk(clk), .rst(rst_n), .cfg_load(cl5), .cfg_birth(cb5), .cfg_survive(cs5),
    .in_valid(v5), .in_ready(r5), .in_state(s5), .in_neighbors(n5),
    .out_valid(ov5), .out_ready(or5), .out_count(c5), .out_next_state(nx5),
    .out_changed(ch5), .busy(b5));

  int n_vec = 0;
  int n_err = 0;

  exp_t        q[2][$];
  exp_t        got[2][$];
  exp_t        held[2];
  bit          stl[2];
  logic [64:0] mb[2];
  logic [64:0] ms[2];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  // Reference: count live neighbors, then look up the mask chosen by the cell state.
  function automatic exp_t model(input bit st, input logic [63:0] nb,
                                 input logic [64:0] b, input logic [64:0] s);
    exp_t e;
    e.cnt = $countones(nb);
    e.nxt = st ? s[e.cnt] : b[e.cnt];
    e.chg = e.nxt ^ st;
    return e;
  endfunction

  task automatic mon(input int k, input bit rn, input bit iv, input bit ir, input bit ist,
                     input logic [63:0] nb, input bit ov, input bit ordy, input int cnt,
                     input bit nx, input bit ch, input bit bz, input bit cl,
                     input logic [64:0] cb, input logic [64:0] cs);
    exp_t a;
    exp_t e;
    if (!rn) begin
      q[k].delete();
      stl[k] = 0;
      mb[k]  = 65'd8;
      ms[k]  = 65'd12;
      return;
    end
    a.cnt = cnt;
    a.nxt = nx;
    a.chg = ch;
    chk($sformatf("in_ready[%0d]", k), ir, !ov || ordy);
    chk($sformatf("busy[%0d]", k), bz, q[k].size() != 0);
    if (stl[k]) begin
      chk($sformatf("hold_valid[%0d]", k), ov, 1);
      chk($sformatf("hold_data[%0d]", k), {a.cnt, a.nxt, a.chg}, {held[k].cnt, held[k].nxt, held[k].chg});
    end
    if (ov) begin
      if (q[k].size() == 0) fail($sformatf("spurious_output[%0d]", k));
      else begin
        e = q[k][0];
        chk($sformatf("count[%0d]", k), a.cnt, e.cnt);
        chk($sformatf("next_state[%0d]", k), a.nxt, e.nxt);
        chk($sformatf("changed[%0d]", k), a.chg, e.chg);
        if (ordy) begin
          void'(q[k].pop_front());
          got[k].push_back(a);
        end
      end
    end
    stl[k]  = ov && !ordy;
    held[k] = a;
    if (iv && ir) q[k].push_back(model(ist, nb, mb[k], ms[k]));
    if (cl) begin
      mb[k] = cb;
      ms[k] = cs;
    end
  endtask

  always @(negedge clk)
    mon(0, rst_n, v8, r8, s8, 64'(n8), ov8, or8, int'(c8), nx8, ch8, b8, cl8, 65'(cb8), 65'(cs8));
  always @(negedge clk)
    mon(1, rst_n, v5, r5, s5, 64'(n5), ov5, or5, int'(c5), nx5, ch5, b5, cl5, 65'(cb5), 65'(cs5));

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send8(input bit st, input logic [7:0] nb);
    int t = 0;
    v8 = 1; s8 = st; n8 = nb;
    @(negedge clk);
    while (!r8 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) fail("send8_timeout");
    @(posedge clk);
    #1;
    v8 = 0; s8 = 1'($urandom_range(0, 1)); n8 = 8'($urandom);
  endtask

  task automatic send5(input bit st, input logic [4:0] nb);
    int t = 0;
    v5 = 1; s5 = st; n5 = nb;
    @(negedge clk);
    while (!r5 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) fail("send5_timeout");
    @(posedge clk);
    #1;
    v5 = 0; s5 = 1'($urandom_range(0, 1)); n5 = 5'($urandom);
  endtask

  task automatic drain8;
    int t = 0;
    while ((b8 || ov8) && t < 200) begin
      step(1);
      t++;
    end
    if (t >= 200) fail("drain8_timeout");
  endtask

  task automatic drain5;
    int t = 0;
    while ((b5 || ov5) && t < 200) begin
      step(1);
      t++;
    end
    if (t >= 200) fail("drain5_timeout");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat;
    bit  done5;
    logic [7:0] sent[6];

    // Reset state
    #3;
    chk("rst_ov8", ov8, 0); chk("rst_cnt8", c8, 0); chk("rst_nx8", nx8, 0);
    chk("rst_ch8", ch8, 0); chk("rst_busy8", b8, 0);
    chk("rst_ov5", ov5, 0); chk("rst_cnt5", c5, 0); chk("rst_nx5", nx5, 0);
    chk("rst_ch5", ch5, 0); chk("rst_busy5", b5, 0);
    step(2);
    rst_n = 1;

    // First beat: birth at 3 neighbors, 4-cycle latency
    v8 = 1; s8 = 0; n8 = 8'h07;
    chk("t1_in_ready", r8, 1);
    step(1);
    v8 = 0;
    lat = 1;
    while (!ov8 && lat < 20) begin
      step(1);
      lat++;
    end
    chk("latency8", lat, 4);
    chk("t1_count", c8, 3); chk("t1_next", nx8, 1); chk("t1_changed", ch8, 1);
    drain8();

    // Survive, death by overcrowding, stays dead
    got[0].delete();
    send8(1, 8'h03); send8(1, 8'hFF); send8(0, 8'h0F);
    drain8();
    chk("t2_n", got[0].size(), 3);
    if (got[0].size() == 3) begin
      chk("t2_c0", got[0][0].cnt, 2); chk("t2_x0", got[0][0].nxt, 1); chk("t2_h0", got[0][0].chg, 0);
      chk("t2_c1", got[0][1].cnt, 8); chk("t2_x1", got[0][1].nxt, 0); chk("t2_h1", got[0][1].chg, 1);
      chk("t2_c2", got[0][2].cnt, 4); chk("t2_x2", got[0][2].nxt, 0); chk("t2_h2", got[0][2].chg, 0);
    end

    // Backpressure mid-stream
    got[0].delete();
    for (int i = 0; i < 6; i++) sent[i] = 8'($urandom);
    fork
      for (int i = 0; i < 6; i++) send8(1'(i & 1), sent[i]);
      begin
        step(3);
        or8 = 0;
        step(5);
        or8 = 1;
      end
    join
    drain8();
    chk("bp_n", got[0].size(), 6);
    if (got[0].size() == 6)
      for (int i = 0; i < 6; i++) chk("bp_order", got[0][i].cnt, $countones(sent[i]));

    // Reconfiguration: birth on 3 or 6
    cl8 = 1; cb8 = 9'b0_0100_1000; cs8 = 9'b0_0000_1100;
    step(1);
    cl8 = 0;
    got[0].delete();
    send8(0, 8'h3F);
    drain8();
    chk("cfg_n", got[0].size(), 1);
    if (got[0].size() == 1) chk("cfg_birth6", got[0][0].nxt, 1);
    // Load lands on the rule-stage edge: that beat must still see the old masks
    send8(0, 8'h3F);
    step(2);
    cl8 = 1; cb8 = 9'd8;
    step(1);
    cl8 = 0;
    chk("same_edge_valid", ov8, 1); chk("same_edge_cnt", c8, 6); chk("same_edge_next", nx8, 1);
    drain8();
    got[0].delete();
    send8(0, 8'h3F);
    drain8();
    if (got[0].size() == 1) chk("cfg_new_next", got[0][0].nxt, 0);
    else fail("cfg_new_missing");

    // Reset with beats in flight
    cl8 = 1; cb8 = 9'b0_0100_1000;
    step(1);
    cl8 = 0;
    or8 = 0;
    send8(0, 8'h07); send8(1, 8'h03); send8(0, 8'h01);
    step(4);
    chk("pre_rst_ov", ov8, 1); chk("pre_rst_busy", b8, 1);
    #2 rst_n = 0;
    #1;
    chk("arst_ov", ov8, 0); chk("arst_cnt", c8, 0); chk("arst_nx", nx8, 0);
    chk("arst_ch", ch8, 0); chk("arst_busy", b8, 0);
    step(1);
    rst_n = 1; or8 = 1;
    step(10);
    chk("post_rst_busy", b8, 0); chk("post_rst_ov", ov8, 0);
    got[0].delete();
    send8(0, 8'h3F);
    drain8();
    if (got[0].size() == 1) chk("default_birth_restored", got[0][0].nxt, 0);
    else fail("post_rst_missing");

    // N=5: latency, odd pass-through bit, all neighbors alive
    v5 = 1; s5 = 1; n5 = 5'b10110;
    step(1);
    v5 = 0;
    lat = 1;
    while (!ov5 && lat < 20) begin
      step(1);
      lat++;
    end
    chk("latency5", lat, 4);
    chk("n5_count", c5, 3); chk("n5_next", nx5, 1); chk("n5_changed", ch5, 0);
    drain5();
    got[1].delete();
    send5(0, 5'b10000); send5(1, 5'b11111);
    drain5();
    chk("n5_dir_n", got[1].size(), 2);
    if (got[1].size() == 2) begin
      chk("n5_odd_cnt", got[1][0].cnt, 1); chk("n5_odd_next", got[1][0].nxt, 0);
      chk("n5_full_cnt", got[1][1].cnt, 5); chk("n5_full_next", got[1][1].nxt, 0);
    end

    // N=5 random stream with random masks and random backpressure
    cl5 = 1; cb5 = 6'($urandom); cs5 = 6'($urandom);
    step(1);
    cl5 = 0;
    got[1].delete();
    done5 = 0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          if ($urandom_range(0, 4) == 0) step(1);
          send5(1'($urandom_range(0, 1)), 5'($urandom));
        end
        done5 = 1;
      end
      begin
        while (!done5) begin
          or5 = ($urandom_range(0, 3) != 0);
          step(1);
        end
      end
    join
    or5 = 1;
    drain5();
    chk("n5_rand_n", got[1].size(), 1000);
    chk("n5_sb_empty", q[1].size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
